// File: rtl/fc_layer_sequencer.sv
// Purpose : sequences one 4-layer fully-connected inference (clear, accumulate, drain, relu per layer).
// Latency : busy for N_L1+N_L2+N_L3+N_L4+12 cycles per run; result_valid on the last busy cycle.
// Backpr. : none; start is ignored while busy (no queueing), abort returns to IDLE on the next cycle.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, abort          run request (sampled in IDLE), cancel (sampled while busy)
//   busy                  high from layer-0 CLEAR through FINISH
//   layer_sel, address    current layer and weight/input element index
//   acc_clr, acc_en       accumulator clear / enable (acc_en lags the address by one cycle)
//   relu_clr, relu_en     activation clear at run start / per-layer capture strobe
//   result_valid          final-layer outputs complete
module fc_layer_sequencer #(
  parameter int N_L1       = 288,
  parameter int N_L2       = 120,
  parameter int N_L3       = 120,
  parameter int N_L4       = 84,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic [1:0]            layer_sel,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  acc_clr,
  output logic                  acc_en,
  output logic                  relu_clr,
  output logic                  relu_en,
  output logic                  result_valid
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ACCUM  = 3'd2,
    S_DRAIN  = 3'd3,
    S_RELU   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_L1 = ADDR_WIDTH'(N_L1 - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_L2 = ADDR_WIDTH'(N_L2 - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_L3 = ADDR_WIDTH'(N_L3 - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_L4 = ADDR_WIDTH'(N_L4 - 1);

  state_t                  state, state_nx;
  logic [1:0]              layer_nx;
  logic [ADDR_WIDTH-1:0]   addr_nx;
  logic [ADDR_WIDTH-1:0]   last_addr;
  logic                    busy_nx, acc_clr_nx, acc_en_nx, relu_clr_nx, relu_en_nx, result_valid_nx;

  // Final element index of the layer being sequenced.
  always_comb begin
    last_addr = LAST_L1;
    case (layer_sel)
      2'd0:    last_addr = LAST_L1;
      2'd1:    last_addr = LAST_L2;
      2'd2:    last_addr = LAST_L3;
      default: last_addr = LAST_L4;
    endcase
  end

  // Next state plus next values of every output; all outputs are registered
  // copies of these, so each output is a pure function of the state it accompanies.
  always_comb begin
    state_nx    = state;
    layer_nx    = layer_sel;
    addr_nx     = '0;
    relu_clr_nx = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx    = S_CLEAR;
          layer_nx    = 2'd0;
          relu_clr_nx = 1'b1;
        end
      end
      S_CLEAR: state_nx = S_ACCUM;
      S_ACCUM: begin
        if (address == last_addr) begin
          state_nx = S_DRAIN;
        end else begin
          addr_nx = address + 1'b1;
        end
      end
      S_DRAIN: state_nx = (layer_sel == 2'd3) ? S_FINISH : S_RELU;
      S_RELU: begin
        state_nx = S_CLEAR;
        layer_nx = layer_sel + 2'd1;
      end
      S_FINISH: begin
        state_nx = S_IDLE;
        layer_nx = 2'd0;
      end
      default: begin
        state_nx = S_IDLE;
        layer_nx = 2'd0;
      end
    endcase

    // Abort overrides everything while busy; in IDLE it is simply not looked at.
    if (state != S_IDLE && abort) begin
      state_nx = S_IDLE;
      layer_nx = 2'd0;
      addr_nx  = '0;
    end

    busy_nx         = (state_nx != S_IDLE);
    acc_clr_nx      = (state_nx == S_CLEAR);
    relu_en_nx      = (state_nx == S_RELU);
    result_valid_nx = (state_nx == S_FINISH);
    // Read data arrives one cycle after the address, so the enable follows
    // the ACCUM state by one cycle rather than the next state.
    acc_en_nx       = (state == S_ACCUM) && !abort;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      layer_sel    <= 2'd0;
      address      <= '0;
      busy         <= 1'b0;
      acc_clr      <= 1'b0;
      acc_en       <= 1'b0;
      relu_clr     <= 1'b0;
      relu_en      <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_nx;
      layer_sel    <= layer_nx;
      address      <= addr_nx;
      busy         <= busy_nx;
      acc_clr      <= acc_clr_nx;
      acc_en       <= acc_en_nx;
      relu_clr     <= relu_clr_nx;
      relu_en      <= relu_en_nx;
      result_valid <= result_valid_nx;
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer: one instance with default layer sizes and one
// with sizes 3,2,2,1, driven by shared start/abort/reset and compared every
// cycle against a run-position model derived from the per-layer schedule.
module tb_fc_layer_sequencer;

  localparam int AW = 11;
  localparam int D1 = 288, D2 = 120, D3 = 120, D4 = 84;
  localparam int S1 = 3, S2 = 2, S3 = 2, S4 = 1;
  localparam int D_TOT = D1 + D2 + D3 + D4 + 12;
  localparam int S_TOT = S1 + S2 + S3 + S4 + 12;

  logic clk = 1'b0;
  logic reset, start, abort;

  logic          d_busy, d_acc_clr, d_acc_en, d_relu_clr, d_relu_en, d_rv;
  logic [1:0]    d_layer;
  logic [AW-1:0] d_addr;
  logic          s_busy, s_acc_clr, s_acc_en, s_relu_clr, s_relu_en, s_rv;
  logic [1:0]    s_layer;
  logic [AW-1:0] s_addr;

  always #5 clk = ~clk;

  fc_layer_sequencer dut_d (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(d_busy), .layer_sel(d_layer), .address(d_addr),
    .acc_clr(d_acc_clr), .acc_en(d_acc_en), .relu_clr(d_relu_clr),
    .relu_en(d_relu_en), .result_valid(d_rv)
  );

  fc_layer_sequencer #(.N_L1(S1), .N_L2(S2), .N_L3(S3), .N_L4(S4), .ADDR_WIDTH(AW)) dut_s (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(s_busy), .layer_sel(s_layer), .address(s_addr),
    .acc_clr(s_acc_clr), .acc_en(s_acc_en), .relu_clr(s_relu_clr),
    .relu_en(s_relu_en), .result_valid(s_rv)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input logic b, input logic [1:0] l, input logic [AW-1:0] a,
                                       input logic cc, input logic ce, input logic rc,
                                       input logic re, input logic rv);
    return {13'd0, b, l, a, cc, ce, rc, re, rv};
  endfunction

  // Expected outputs at position pos of a run (pos < 0 means idle).
  // Each layer occupies N+3 cycles: CLEAR, N ACCUM cycles, DRAIN, then RELU or FINISH.
  function automatic logic [31:0] exp_vec(input int pos, input int n0, input int n1,
                                          input int n2, input int n3);
    int n [4];
    int off;
    n[0] = n0; n[1] = n1; n[2] = n2; n[3] = n3;
    if (pos < 0) return 32'd0;
    off = pos;
    for (int l = 0; l < 4; l++) begin
      if (off < n[l] + 3) begin
        if (off == 0)
          return pack(1'b1, 2'(l), '0, 1'b1, 1'b0, (l == 0), 1'b0, 1'b0);
        else if (off <= n[l])
          return pack(1'b1, 2'(l), AW'(off - 1), 1'b0, (off > 1), 1'b0, 1'b0, 1'b0);
        else if (off == n[l] + 1)
          return pack(1'b1, 2'(l), '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        else
          return pack(1'b1, 2'(l), '0, 1'b0, 1'b0, 1'b0, (l < 3), (l == 3));
      end
      off -= n[l] + 3;
    end
    return 32'hdead_beef;
  endfunction

  function automatic int step(input int pos, input int total);
    if (pos < 0) return start ? 0 : -1;
    if (abort) return -1;
    if (pos == total - 1) return -1;
    return pos + 1;
  endfunction

  int pos_d = -1;
  int pos_s = -1;

  // Monitor state for the single default-size run.
  bit mon = 1'b0;
  int cyc = 0;
  int busy_cnt, relu_cnt, rv_cnt, run_len, last_busy_cyc, rv_cyc;
  int runs [$];

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      pos_d = -1;
      pos_s = -1;
    end else begin
      pos_d = step(pos_d, D_TOT);
      pos_s = step(pos_s, S_TOT);
    end
    @(negedge clk);
    cyc++;
    check("dflt_vec", pack(d_busy, d_layer, d_addr, d_acc_clr, d_acc_en, d_relu_clr, d_relu_en, d_rv),
          exp_vec(pos_d, D1, D2, D3, D4));
    check("small_vec", pack(s_busy, s_layer, s_addr, s_acc_clr, s_acc_en, s_relu_clr, s_relu_en, s_rv),
          exp_vec(pos_s, S1, S2, S3, S4));
    check("en_clr_excl", 32'((d_acc_en & d_acc_clr) | (s_acc_en & s_acc_clr)), 32'd0);
    check("relu_l3", 32'((d_relu_en && d_layer == 2'd3) || (s_relu_en && s_layer == 2'd3)), 32'd0);
    if (mon) begin
      if (d_busy) begin busy_cnt++; last_busy_cyc = cyc; end
      if (d_relu_en) relu_cnt++;
      if (d_rv) begin rv_cnt++; rv_cyc = cyc; end
      if (d_acc_en) run_len++;
      else if (run_len > 0) begin runs.push_back(run_len); run_len = 0; end
    end
  endtask

  initial begin
    int waited, gap, s_runs;
    bit seen_busy, prev_busy;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    #1;
    check("reset_async", pack(s_busy, s_layer, s_addr, s_acc_clr, s_acc_en, s_relu_clr, s_relu_en, s_rv), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();

    // Full run at default sizes.
    busy_cnt = 0; relu_cnt = 0; rv_cnt = 0; run_len = 0; last_busy_cyc = -1; rv_cyc = -2;
    mon = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (650) tick();
    mon = 1'b0;
    check("busy_len", busy_cnt, D_TOT);
    check("relu_pulses", relu_cnt, 3);
    check("rv_pulses", rv_cnt, 1);
    check("rv_last_busy", rv_cyc, last_busy_cyc);
    check("acc_runs", runs.size(), 4);
    if (runs.size() == 4) begin
      check("acc_run0", runs[0], D1);
      check("acc_run1", runs[1], D2);
      check("acc_run2", runs[2], D3);
      check("acc_run3", runs[3], D4);
    end

    // Abort the small instance in layer 2 at address 1.
    start = 1'b1; tick(); start = 1'b0;
    waited = 0;
    while (!(s_layer == 2'd2 && s_addr == AW'(1)) && waited < 40) begin tick(); waited++; end
    check("abort_reach", 32'(waited < 40), 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_idle", pack(s_busy, s_layer, s_addr, s_acc_clr, s_acc_en, s_relu_clr, s_relu_en, s_rv), 32'd0);
    repeat (3) tick();
    busy_cnt = 0;
    start = 1'b1; tick(); start = 1'b0;
    busy_cnt += s_busy;
    repeat (29) begin tick(); busy_cnt += s_busy; end
    check("rerun_busy", busy_cnt, S_TOT);

    // Start held high: runs back to back with exactly one idle cycle between.
    start = 1'b1;
    seen_busy = 1'b0; prev_busy = 1'b0; gap = 0; s_runs = 0;
    repeat (80) begin
      tick();
      if (s_busy && !prev_busy) begin
        if (seen_busy) check("b2b_gap", gap, 1);
        s_runs++;
        seen_busy = 1'b1;
      end
      gap = s_busy ? 0 : gap + 1;
      prev_busy = s_busy;
    end
    start = 1'b0;
    check("b2b_runs", 32'(s_runs >= 3), 32'd1);
    repeat (25) tick();

    // Asynchronous reset in the middle of an accumulate phase.
    start = 1'b1; tick(); start = 1'b0;
    waited = 0;
    while (s_addr != AW'(1) && waited < 10) begin tick(); waited++; end
    check("rst_reach", 32'(waited < 10), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_s", pack(s_busy, s_layer, s_addr, s_acc_clr, s_acc_en, s_relu_clr, s_relu_en, s_rv), 32'd0);
    check("rst_mid_d", pack(d_busy, d_layer, d_addr, d_acc_clr, d_acc_en, d_relu_clr, d_relu_en, d_rv), 32'd0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (25) tick();

    // Random start/abort traffic.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 39) == 0);
      tick();
    end
    start = 1'b0; abort = 1'b0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
